// File: rtl/serial_rx_fifo_pkg.sv
// Shared serial receive constants and helpers.
// Byte width, error counter width and saturation value.
package serial_rx_fifo_pkg;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned ERRCNT_W = 8;
    localparam logic [ERRCNT_W-1:0] ERRCNT_MAX = 8'hFF;

    function automatic logic [ERRCNT_W-1:0] errcnt_inc(
        input logic [ERRCNT_W-1:0] c
    );
        return (c == ERRCNT_MAX) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/serial_rx_fifo_mem.sv
// Byte storage for the receive FIFO.
// Synchronous write, asynchronous read, no reset.
module serial_rx_fifo_mem
    import serial_rx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_x4,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [BYTE_W-1:0]     i_wdata,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [BYTE_W-1:0]     o_rdata
);

    logic [BYTE_W-1:0] r_mem [2**DEPTH_LOG2];

    always_ff @(posedge clk_x4) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/serial_rx_fifo.sv
// Receive FWFT FIFO with sticky framing/overrun status.
// SERIAL_RX_FIFO_ERRCNT_EN adds the saturating o_error_count.
module serial_rx_fifo
    import serial_rx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_x4,
    input  logic                  rst_x,
    input  logic [BYTE_W-1:0]     i_data,
    input  logic                  i_valid,
    input  logic                  i_error,
    input  logic                  i_ready,
    input  logic                  i_flush,
    input  logic                  i_clear,
    output logic [BYTE_W-1:0]     o_data,
    output logic                  o_valid,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_overrun,
    output logic                  o_frame_error
`ifdef SERIAL_RX_FIFO_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0]   o_error_count
`endif
);

    localparam int unsigned DEPTH = 2**DEPTH_LOG2;

    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [DEPTH_LOG2:0]   w_count_nxt;
    logic                  r_valid;
    logic                  r_overrun;
    logic                  r_frame;
    logic                  w_full;
    logic                  w_space;
    logic                  w_good;
    logic                  w_push;
    logic                  w_pop;
    logic [BYTE_W-1:0]     w_rdata;

    assign w_full  = (r_count == (DEPTH_LOG2+1)'(DEPTH));
    assign w_space = !w_full || (r_valid && i_ready);
    // Framing error beats a coincident good strobe.
    assign w_good  = i_valid && !i_error;
    assign w_push  = w_good && w_space && !i_flush;
    assign w_pop   = r_valid && i_ready && !i_flush;

    always_comb begin
        w_count_nxt = r_count;
        if (i_flush) begin
            w_count_nxt = '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + 1'b1;
                2'b01:   w_count_nxt = r_count - 1'b1;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    always_ff @(posedge clk_x4 or negedge rst_x) begin
        if (!rst_x) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
            if (i_flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Set beats clear when both land on the same edge.
    always_ff @(posedge clk_x4 or negedge rst_x) begin
        if (!rst_x) begin
            r_overrun <= 1'b0;
            r_frame   <= 1'b0;
        end else begin
            r_overrun <= (w_good && !w_space) || (r_overrun && !i_clear);
            r_frame   <= i_error || (r_frame && !i_clear);
        end
    end

`ifdef SERIAL_RX_FIFO_ERRCNT_EN
    logic [ERRCNT_W-1:0] r_errcnt;

    always_ff @(posedge clk_x4 or negedge rst_x) begin
        if (!rst_x) begin
            r_errcnt <= '0;
        end else if (i_clear) begin
            r_errcnt <= ERRCNT_W'(i_error);
        end else if (i_error) begin
            r_errcnt <= errcnt_inc(r_errcnt);
        end
    end

    assign o_error_count = r_errcnt;
`endif

    serial_rx_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk_x4  (clk_x4),
        .i_we    (w_push),
        .i_waddr (r_wptr),
        .i_wdata (i_data),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    assign o_data        = r_valid ? w_rdata : '0;
    assign o_valid       = r_valid;
    assign o_count       = r_count;
    assign o_overrun     = r_overrun;
    assign o_frame_error = r_frame;

endmodule

// File: tb/tb_serial_rx_fifo.sv
// Directed self-checking bench for serial_rx_fifo.
// Error-count checks compile in with SERIAL_RX_FIFO_ERRCNT_EN.
module tb_serial_rx_fifo;

    logic       clk_x4 = 1'b0;
    logic       rst_x;
    logic [7:0] i_data;
    logic       i_valid;
    logic       i_error;
    logic       i_ready;
    logic       i_flush;
    logic       i_clear;
    logic [7:0] o_data;
    logic       o_valid;
    logic [4:0] o_count;
    logic       o_overrun;
    logic       o_frame_error;
`ifdef SERIAL_RX_FIFO_ERRCNT_EN
    logic [7:0] o_error_count;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk_x4 = ~clk_x4;

    serial_rx_fifo #(
        .DEPTH_LOG2 (4)
    ) dut (
        .clk_x4        (clk_x4),
        .rst_x         (rst_x),
        .i_data        (i_data),
        .i_valid       (i_valid),
        .i_error       (i_error),
        .i_ready       (i_ready),
        .i_flush       (i_flush),
        .i_clear       (i_clear),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .o_count       (o_count),
        .o_overrun     (o_overrun),
        .o_frame_error (o_frame_error)
`ifdef SERIAL_RX_FIFO_ERRCNT_EN
        ,
        .o_error_count (o_error_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_x4);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        i_data  = d;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic pulse_err();
        i_error = 1'b1;
        tick();
        i_error = 1'b0;
    endtask

    initial begin
        rst_x   = 1'b0;
        i_data  = 8'h00;
        i_valid = 1'b0;
        i_error = 1'b0;
        i_ready = 1'b0;
        i_flush = 1'b0;
        i_clear = 1'b0;
        #23;
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 8'h00);
        chk("rst_count", o_count, 0);
        chk("rst_ovr", o_overrun, 0);
        chk("rst_frm", o_frame_error, 0);
`ifdef SERIAL_RX_FIFO_ERRCNT_EN
        chk("rst_ecnt", o_error_count, 0);
`endif
        rst_x = 1'b1;
        tick();

        // Basic FWFT ordering
        push(8'h41);
        chk("lat_valid", o_valid, 1);
        chk("lat_data", o_data, 8'h41);
        push(8'h42);
        push(8'h43);
        chk("b_count", o_count, 3);
        chk("b_head", o_data, 8'h41);
        i_ready = 1'b1;
        chk("b_pop0", o_data, 8'h41);
        tick();
        chk("b_pop1", o_data, 8'h42);
        tick();
        chk("b_pop2", o_data, 8'h43);
        tick();
        chk("b_empty_v", o_valid, 0);
        chk("b_empty_d", o_data, 8'h00);
        tick();
        chk("rdy_empty_cnt", o_count, 0);
        i_ready = 1'b0;

        // Overrun on the 17th byte
        for (int i = 0; i < 17; i++) push(8'(i));
        chk("ovr_count", o_count, 16);
        chk("ovr_flag", o_overrun, 1);
        i_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovr_drain%0d", i), o_data, 32'(i));
            tick();
        end
        i_ready = 1'b0;
        chk("ovr_empty", o_valid, 0);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        chk("ovr_clear", o_overrun, 0);

        // Push and pop together while full
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
        chk("full_count", o_count, 16);
        i_data  = 8'hAA;
        i_valid = 1'b1;
        i_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        i_ready = 1'b0;
        chk("fpp_count", o_count, 16);
        chk("fpp_ovr", o_overrun, 0);
        i_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("fpp_drain%0d", i), o_data, 32'(8'h21 + i));
            tick();
        end
        chk("fpp_last", o_data, 8'hAA);
        tick();
        i_ready = 1'b0;
        chk("fpp_empty", o_count, 0);

        // Framing errors
        pulse_err();
        push(8'h55);
        pulse_err();
        pulse_err();
        chk("fe_count", o_count, 1);
        chk("fe_head", o_data, 8'h55);
        chk("fe_flag", o_frame_error, 1);
`ifdef SERIAL_RX_FIFO_ERRCNT_EN
        chk("fe_ecnt3", o_error_count, 3);
`endif
        i_data  = 8'h66;
        i_valid = 1'b1;
        i_error = 1'b1;
        tick();
        i_valid = 1'b0;
        i_error = 1'b0;
        chk("fe_both_cnt", o_count, 1);
`ifdef SERIAL_RX_FIFO_ERRCNT_EN
        chk("fe_both_ecnt", o_error_count, 4);
`endif
        i_clear = 1'b1;
        i_error = 1'b1;
        tick();
        i_clear = 1'b0;
        i_error = 1'b0;
        chk("clr_set_frm", o_frame_error, 1);
`ifdef SERIAL_RX_FIFO_ERRCNT_EN
        chk("clr_set_ecnt", o_error_count, 1);
`endif
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        chk("clr_frm", o_frame_error, 0);
        for (int i = 0; i < 300; i++) pulse_err();
        chk("sat_frm", o_frame_error, 1);
`ifdef SERIAL_RX_FIFO_ERRCNT_EN
        chk("sat_ecnt", o_error_count, 8'hFF);
`endif
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("fe_drain", o_valid, 0);

        // Flush with a coincident push and pop
        for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
        chk("fl_pre", o_count, 5);
        i_flush = 1'b1;
        i_valid = 1'b1;
        i_ready = 1'b1;
        i_data  = 8'h77;
        tick();
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        chk("fl_count", o_count, 0);
        chk("fl_valid", o_valid, 0);
        chk("fl_data", o_data, 8'h00);
        chk("fl_frm", o_frame_error, 1);
        chk("fl_ovr", o_overrun, 0);
        push(8'h88);
        chk("fl_next", o_data, 8'h88);
        chk("fl_next_cnt", o_count, 1);

        // Async reset mid-pop
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        for (int i = 0; i < 6; i++) push(8'(8'h90 + i));
        i_ready = 1'b1;
        tick();
        chk("ar_pre", o_data, 8'h91);
        #2;
        rst_x = 1'b0;
        #1;
        chk("ar_valid", o_valid, 0);
        chk("ar_data", o_data, 8'h00);
        chk("ar_count", o_count, 0);
        chk("ar_frm", o_frame_error, 0);
`ifdef SERIAL_RX_FIFO_ERRCNT_EN
        chk("ar_ecnt", o_error_count, 0);
`endif
        i_ready = 1'b0;
        #1;
        rst_x = 1'b1;
        tick();
        push(8'h99);
        chk("ar_after", o_data, 8'h99);
        chk("ar_after_cnt", o_count, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
